// File: rtl/cpu_io_responder.sv
// cpu_io_responder: peripheral-side partner of the CPU I/O pins (RX FIFO -> data_in, data_out -> TX FIFO, interrupt FSM).
// Latency: an RX word reaches cpu_data_in one edge after its push; interrupt rises one edge after rx_count becomes non-zero.
// Backpressure: ext_in_ready drops when RX is full; TX holds its head while ext_out_ready=0, and CPU writes into a full TX are dropped.
// Optional feature macro: IO_OVF_COUNT_EN (builds the saturating dropped-write counter behind ovf_count).
module cpu_io_responder #(
  parameter int DEPTH       = 4,
  parameter int WIDTH       = 16,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ext_in_valid,
  input  logic [WIDTH-1:0]         ext_in_data,
  output logic                     ext_in_ready,
  output logic [WIDTH-1:0]         cpu_data_in,
  input  logic                     cpu_rd,
  input  logic [WIDTH-1:0]         cpu_data_out,
  input  logic                     cpu_wr,
  output logic                     ext_out_valid,
  output logic [WIDTH-1:0]         ext_out_data,
  input  logic                     ext_out_ready,
  output logic                     interrupt,
  input  logic                     int_ack,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     tx_overflow,
  output logic [7:0]               ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    HOLD_LD  = 4'(HOLDOFF_CYC);

  // ---------------------------------------------------------------- RX FIFO
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wr_ptr;
  logic [AW-1:0]    rx_rd_ptr;
  logic [CW-1:0]    rx_cnt;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_not_empty;

  assign rx_not_empty = (rx_cnt != '0);
  assign ext_in_ready = (rx_cnt != FULL_CNT);
  assign rx_push      = ext_in_valid && ext_in_ready;
  assign rx_pop       = cpu_rd && rx_not_empty;
  assign cpu_data_in  = rx_not_empty ? rx_mem[rx_rd_ptr] : '0;
  assign rx_count     = rx_cnt;

  // RX storage: written on push only; stale contents are hidden by the count.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= ext_in_data;
    end
  end

  // RX pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wr_ptr;
  logic [AW-1:0]    tx_rd_ptr;
  logic [CW-1:0]    tx_cnt;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_drop;
  logic             tx_ovf_q;

  assign tx_full       = (tx_cnt == FULL_CNT);
  assign ext_out_valid = (tx_cnt != '0);
  assign ext_out_data  = ext_out_valid ? tx_mem[tx_rd_ptr] : '0;
  assign tx_pop        = ext_out_valid && ext_out_ready;
  // A pop on a full FIFO frees the slot in the same edge, so the write still lands.
  assign tx_push       = cpu_wr && (!tx_full || tx_pop);
  assign tx_drop       = cpu_wr && tx_full && !tx_pop;
  assign tx_overflow   = tx_ovf_q;

  // TX storage: written on accepted CPU writes only.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= cpu_data_out;
    end
  end

  // TX pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      tx_ovf_q  <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (tx_drop) tx_ovf_q <= 1'b1;
    end
  end

`ifdef IO_OVF_COUNT_EN
  logic [7:0] ovf_q;
  assign ovf_count = ovf_q;

  // Dropped-write counter, saturating at 255, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 8'd0;
    end else if (tx_drop && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end
`else
  assign ovf_count = 8'd0;
`endif

  // ---------------------------------------------------------- interrupt FSM
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] hold_cnt;
  logic       interrupt_q;

  assign interrupt = interrupt_q;

  // Interrupt request with ack and hold-off; interrupt is registered alongside the state.
  // Leaving HOLDOFF folds the IDLE re-check into the same edge, so interrupt stays low
  // for exactly HOLDOFF_CYC cycles when words are still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= 4'd0;
      interrupt_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_not_empty) begin
            state       <= ST_ASSERT;
            interrupt_q <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (int_ack) begin
            state       <= ST_HOLDOFF;
            hold_cnt    <= HOLD_LD;
            interrupt_q <= 1'b0;
          end else if (!rx_not_empty) begin
            state       <= ST_IDLE;
            interrupt_q <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt <= 4'd1) begin
            if (rx_not_empty) begin
              state       <= ST_ASSERT;
              interrupt_q <= 1'b1;
            end else begin
              state       <= ST_IDLE;
              interrupt_q <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          interrupt_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder (DEPTH=4, WIDTH=16, HOLDOFF_CYC=2).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Optional ovf_count expectation follows IO_OVF_COUNT_EN.
module tb_cpu_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_in_valid;
  logic [15:0] ext_in_data;
  logic        ext_in_ready;
  logic [15:0] cpu_data_in;
  logic        cpu_rd;
  logic [15:0] cpu_data_out;
  logic        cpu_wr;
  logic        ext_out_valid;
  logic [15:0] ext_out_data;
  logic        ext_out_ready;
  logic        interrupt;
  logic        int_ack;
  logic [2:0]  rx_count;
  logic        tx_overflow;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

`ifdef IO_OVF_COUNT_EN
  localparam logic [7:0] OVF_EXP = 8'd1;
`else
  localparam logic [7:0] OVF_EXP = 8'd0;
`endif

  cpu_io_responder #(.DEPTH(4), .WIDTH(16), .HOLDOFF_CYC(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ext_in_valid (ext_in_valid),
    .ext_in_data  (ext_in_data),
    .ext_in_ready (ext_in_ready),
    .cpu_data_in  (cpu_data_in),
    .cpu_rd       (cpu_rd),
    .cpu_data_out (cpu_data_out),
    .cpu_wr       (cpu_wr),
    .ext_out_valid(ext_out_valid),
    .ext_out_data (ext_out_data),
    .ext_out_ready(ext_out_ready),
    .interrupt    (interrupt),
    .int_ack      (int_ack),
    .rx_count     (rx_count),
    .tx_overflow  (tx_overflow),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ext_in_valid = 1'b0; ext_in_data = '0; cpu_rd = 1'b0;
    cpu_data_out = '0; cpu_wr = 1'b0; ext_out_ready = 1'b0; int_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ext_in_ready); end
    checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ext_out_valid); end
    checks++; if (cpu_data_in !== 16'h0) begin errors++; $display("FAIL reset_data_in got %h exp 0000", cpu_data_in); end
    checks++; if (ext_out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0000", ext_out_data); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt got %b exp 0", interrupt); end
    checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL reset_rx_count got %0d exp 0", rx_count); end
    checks++; if (tx_overflow !== 1'b0 || ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf got %b/%0d exp 0/0", tx_overflow, ovf_count); end
  endtask

  task automatic test_single_push();
    ext_in_valid = 1'b1; ext_in_data = 16'h1234;
    step();
    ext_in_valid = 1'b0;
    checks++; if (cpu_data_in !== 16'h1234) begin errors++; $display("FAIL t1_data_in got %h exp 1234", cpu_data_in); end
    checks++; if (rx_count !== 3'd1) begin errors++; $display("FAIL t1_rx_count got %0d exp 1", rx_count); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t1_int_early got %b exp 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL t1_int_rise got %b exp 1", interrupt); end
    cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    checks++; if (rx_count !== 3'd0 || cpu_data_in !== 16'h0) begin errors++; $display("FAIL t1_pop got %0d/%h exp 0/0000", rx_count, cpu_data_in); end
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t1_int_fall got %b exp 0", interrupt); end
  endtask

  task automatic test_rx_full();
    ext_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_in_data = 16'h00A0 + 16'(i);
      step();
    end
    checks++; if (ext_in_ready !== 1'b0 || rx_count !== 3'd4) begin errors++; $display("FAIL t2_full got rdy=%b cnt=%0d exp 0/4", ext_in_ready, rx_count); end
    ext_in_data = 16'h00A4;
    step();
    checks++; if (rx_count !== 3'd4 || cpu_data_in !== 16'h00A0) begin errors++; $display("FAIL t2_blocked got cnt=%0d head=%h exp 4/00a0", rx_count, cpu_data_in); end
    cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    checks++; if (rx_count !== 3'd3 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL t2_first_pop got cnt=%0d rdy=%b exp 3/1", rx_count, ext_in_ready); end
    step();
    ext_in_valid = 1'b0;
    checks++; if (rx_count !== 3'd4) begin errors++; $display("FAIL t2_a4_accept got %0d exp 4", rx_count); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (cpu_data_in !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL t2_order got %h exp %h", cpu_data_in, 16'h00A0 + 16'(i)); end
      cpu_rd = 1'b1;
      step();
      cpu_rd = 1'b0;
    end
    step();
    checks++; if (rx_count !== 3'd0 || interrupt !== 1'b0) begin errors++; $display("FAIL t2_empty got cnt=%0d int=%b exp 0/0", rx_count, interrupt); end
  endtask

  task automatic test_holdoff();
    ext_in_valid = 1'b1; ext_in_data = 16'h00B0;
    step();
    ext_in_data = 16'h00B1;
    step();
    ext_in_valid = 1'b0;
    checks++; if (interrupt !== 1'b1 || rx_count !== 3'd2) begin errors++; $display("FAIL t3_pre got int=%b cnt=%0d exp 1/2", interrupt, rx_count); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t3_hold1 got %b exp 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t3_hold2 got %b exp 0", interrupt); end
    step();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL t3_reassert got %b exp 1", interrupt); end
    cpu_rd = 1'b1;
    step(); step();
    cpu_rd = 1'b0;
    step();
    checks++; if (interrupt !== 1'b0 || rx_count !== 3'd0) begin errors++; $display("FAIL t3_drain got int=%b cnt=%0d exp 0/0", interrupt, rx_count); end
  endtask

  task automatic test_tx_overflow();
    ext_out_ready = 1'b0;
    cpu_wr = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cpu_data_out = 16'(i);
      step();
    end
    checks++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h0001 || tx_overflow !== 1'b0) begin errors++; $display("FAIL t4_full got v=%b d=%h ovf=%b exp 1/0001/0", ext_out_valid, ext_out_data, tx_overflow); end
    cpu_data_out = 16'h0005;
    step();
    cpu_wr = 1'b0;
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf_flag got %b exp 1", tx_overflow); end
    checks++; if (ovf_count !== OVF_EXP) begin errors++; $display("FAIL t4_ovf_count got %0d exp %0d", ovf_count, OVF_EXP); end
    step();
    checks++; if (ext_out_data !== 16'h0001 || ext_out_valid !== 1'b1) begin errors++; $display("FAIL t4_hold got v=%b d=%h exp 1/0001", ext_out_valid, ext_out_data); end
    ext_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++; if (ext_out_data !== 16'(i) || ext_out_valid !== 1'b1) begin errors++; $display("FAIL t4_drain got v=%b d=%h exp 1/%h", ext_out_valid, ext_out_data, 16'(i)); end
      step();
    end
    checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL t4_empty got %b exp 0", ext_out_valid); end
    // Refill to full, then write in the same cycle as a pop.
    ext_out_ready = 1'b0;
    cpu_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_data_out = 16'h0010 + 16'(i);
      step();
    end
    cpu_data_out = 16'h0014; ext_out_ready = 1'b1;
    step();
    cpu_wr = 1'b0;
    checks++; if (ovf_count !== OVF_EXP) begin errors++; $display("FAIL t4_pop_wr_cnt got %0d exp %0d", ovf_count, OVF_EXP); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (ext_out_data !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL t4_pop_wr got %h exp %h", ext_out_data, 16'h0010 + 16'(i)); end
      step();
    end
    ext_out_ready = 1'b0;
    checks++; if (ext_out_valid !== 1'b0 || tx_overflow !== 1'b1) begin errors++; $display("FAIL t4_final got v=%b ovf=%b exp 0/1", ext_out_valid, tx_overflow); end
  endtask

  task automatic test_idle_ignored();
    cpu_rd = 1'b1; int_ack = 1'b1;
    step();
    cpu_rd = 1'b0; int_ack = 1'b0;
    checks++; if (rx_count !== 3'd0 || cpu_data_in !== 16'h0 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL t5_empty_rd got cnt=%0d d=%h rdy=%b exp 0/0000/1", rx_count, cpu_data_in, ext_in_ready); end
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t5_idle_ack got %b exp 0", interrupt); end
  endtask

  task automatic test_reset_midflight();
    ext_in_valid = 1'b1; cpu_wr = 1'b1; ext_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ext_in_data = 16'h00C0 + 16'(i);
      cpu_data_out = 16'h00D0 + 16'(i);
      step();
    end
    ext_in_valid = 1'b0; cpu_wr = 1'b0;
    checks++; if (interrupt !== 1'b1 || rx_count !== 3'd3 || ext_out_data !== 16'h00D0) begin errors++; $display("FAIL t6_pre got int=%b cnt=%0d tx=%h exp 1/3/00d0", interrupt, rx_count, ext_out_data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (interrupt !== 1'b0 || rx_count !== 3'd0 || cpu_data_in !== 16'h0) begin errors++; $display("FAIL t6_rx got int=%b cnt=%0d d=%h exp 0/0/0000", interrupt, rx_count, cpu_data_in); end
    checks++; if (ext_out_valid !== 1'b0 || ext_out_data !== 16'h0 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL t6_tx got v=%b d=%h rdy=%b exp 0/0000/1", ext_out_valid, ext_out_data, ext_in_ready); end
    checks++; if (tx_overflow !== 1'b0 || ovf_count !== 8'd0) begin errors++; $display("FAIL t6_ovf got %b/%0d exp 0/0", tx_overflow, ovf_count); end
    step();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL t6_post got %b exp 0", interrupt); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_rx_full();
    test_holdoff();
    test_tx_overflow();
    test_idle_ignored();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_io_responder.md
Name: cpu_io_responder

Overview:
- Peripheral-side partner of the 16-bit pipelined CPU's I/O pins: it produces the CPU's `data_in` word and `interrupt`, and it consumes the CPU's `data_out` word.
- Buffers words arriving from an external producer in an RX FIFO and presents the FIFO head to the CPU.
- Requests service through an interrupt FSM with acknowledge and hold-off.
- Captures CPU output words into a TX FIFO, which drains to an external consumer over a valid/ready handshake.

Parameters:
- DEPTH, 4, entries per FIFO; power of 2, at least 2.
- WIDTH, 16, data word width.
- HOLDOFF_CYC, 2, idle cycles after `int_ack` before `interrupt` may re-assert; range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ext_in_valid  input  1  external RX word valid.
- ext_in_data  input  WIDTH  external RX word.
- ext_in_ready  output  1  RX FIFO can accept a word.
- cpu_data_in  output  WIDTH  RX FIFO head, driven to the CPU `data_in`.
- cpu_rd  input  1  single-cycle pulse: CPU consumed `cpu_data_in`.
- cpu_data_out  input  WIDTH  from the CPU `data_out`.
- cpu_wr  input  1  single-cycle pulse: `cpu_data_out` is valid, capture it.
- ext_out_valid  output  1  TX word available.
- ext_out_data  output  WIDTH  TX FIFO head.
- ext_out_ready  input  1  external consumer accepts the word.
- interrupt  output  1  to the CPU `interrupt`, registered.
- int_ack  input  1  single-cycle pulse: CPU acknowledges the interrupt.
- rx_count  output  log2(DEPTH)+1  RX occupancy, 0..DEPTH.
- tx_overflow  output  1  sticky: a CPU write was dropped.
- ovf_count  output  8  dropped-write counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high. Reset overrides every other input in the same cycle.
- Reset values:
  - Both FIFOs empty; pointers = 0.
  - `ext_in_ready`=1, `ext_out_valid`=0, `cpu_data_in`=0, `ext_out_data`=0.
  - `interrupt`=0, FSM state = IDLE, `rx_count`=0, `tx_overflow`=0, `ovf_count`=0.
  - A reset during a transfer discards all buffered words.
- RX FIFO:
  - `ext_in_ready` = (`rx_count` != DEPTH), combinational from registered state.
  - Push occurs when `ext_in_valid` && `ext_in_ready`.
  - Pop occurs when `cpu_rd` && `rx_count` != 0. `cpu_rd` on an empty FIFO is ignored.
  - `cpu_data_in` = head word, fall-through, combinational from FIFO storage. It is 0 when the FIFO is empty.
  - A pushed word is visible on `cpu_data_in` the cycle after the push edge, if the FIFO was empty.
  - Simultaneous push and pop: count unchanged. When full, no push is possible (ready=0), so a pop simply frees a slot.
  - Pointers wrap modulo DEPTH.
- TX FIFO:
  - Push occurs on `cpu_wr` when not full.
  - `cpu_wr` when full: the word is dropped, `tx_overflow` is set to 1 and stays at 1 until reset.
  - `cpu_wr` in the same cycle as a pop on a full FIFO is accepted, because the pop frees the slot in the same edge.
  - `ext_out_valid` = TX FIFO not empty. `ext_out_data` = head.
  - Pop occurs on `ext_out_valid` && `ext_out_ready`.
  - `ext_out_data` and `ext_out_valid` are held stable while `ext_out_ready`=0.
- Interrupt FSM (states IDLE, ASSERT, HOLDOFF):
  - IDLE: `interrupt`=0. Moves to ASSERT at the edge where `rx_count` != 0.
  - ASSERT: `interrupt`=1.
    - `int_ack` → HOLDOFF, load hold-off counter with HOLDOFF_CYC.
    - Otherwise, if `rx_count`==0 → IDLE.
    - `int_ack` has priority over the empty condition.
  - HOLDOFF: `interrupt`=0. Counter decrements each cycle. At counter==1 → IDLE.
  - `int_ack` in IDLE or HOLDOFF is ignored.
- Latency: `interrupt` rises exactly one edge after `rx_count` becomes non-zero.

Optional Feature:
- Macro: `IO_OVF_COUNT_EN`.
- Defined: `ovf_count` increments on each dropped `cpu_wr` and saturates at 255. It is cleared only by reset.
- Undefined: no counter logic is built and `ovf_count` is tied to 0. `tx_overflow` behaves identically in both builds.

Test Plan (DEPTH=4, HOLDOFF_CYC=2):
1. Reset, then push 0x1234 via ext_in → next cycle `cpu_data_in`=0x1234, `rx_count`=1; `interrupt`=1 one edge later.
2. Push 5 words 0xA0..0xA4 with `ext_in_valid` held high → `ext_in_ready`=0 after 4 accepted, `rx_count`=4; `cpu_rd` ×4 returns 0xA0..0xA3 in order; 0xA4 is accepted after the first pop.
3. With `interrupt`=1, pulse `int_ack` while `rx_count`=2 → `interrupt` low for exactly 2 cycles (HOLDOFF), then high again.
4. `cpu_wr` 5 words 0x0001..0x0005 with `ext_out_ready`=0 → `ext_out_data`=0x0001 held; `tx_overflow`=1; `ovf_count`=1 with `IO_OVF_COUNT_EN`, 0 without. Raise ready → 0x0001..0x0004 drained.
5. `cpu_rd` on empty RX plus `int_ack` in IDLE → no state change, `rx_count`=0, `cpu_data_in`=0.
6. Assert `reset` with both FIFOs holding 3 words and `interrupt`=1 → next cycle all outputs at reset values, `tx_overflow`=0.
